// File: rtl/rr_arb_pkg.sv
// Shared constants, state encoding and the round-robin pick helper
// for the 4-requester arbiter.
package rr_arb_pkg;
  localparam int NUM_REQ = 4;
  localparam int SEL_W   = 2;

  typedef enum logic {IDLE, GRANT} arb_state_t;

  // First set bit of v, scanning ptr, ptr+1, ... with 2-bit wraparound.
  function automatic logic [SEL_W-1:0] rr_pick(logic [NUM_REQ-1:0] v, logic [SEL_W-1:0] ptr);
    logic [SEL_W-1:0] idx;
    logic             found;
    rr_pick = ptr;
    found   = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = ptr + SEL_W'(i);
      if (v[idx] && !found) begin
        rr_pick = idx;
        found   = 1'b1;
      end
    end
  endfunction
endpackage

// File: rtl/rr_arb_mux_4to1_mux.sv
// One bit-slice of the output mux: picks bit b of the four-bit lane vector a.
module mux_4to1 (
  input  logic [3:0] a,
  input  logic [1:0] b,
  output logic       y
);
  assign y = a[b];
endmodule

// File: rtl/rr_arb_mux_4to1.sv
// Round-robin arbiter driving the select of a WIDTH-bit 4:1 mux, with a
// valid/ready handshake toward the consumer and a stalled-grant timeout.
module rr_arb_mux_4to1
  import rr_arb_pkg::*;
#(
  parameter int WIDTH   = 8,
  parameter int TIMEOUT = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req,
  input  logic [NUM_REQ*WIDTH-1:0] in_data,
  input  logic                     out_ready,
  output logic [NUM_REQ-1:0]       gnt,
  output logic [NUM_REQ-1:0]       ack,
  output logic [SEL_W-1:0]         sel,
  output logic                     out_valid,
  output logic [WIDTH-1:0]         out_data,
  output logic                     timeout,
  output logic                     busy
);
  localparam int HOLD_W = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);

  arb_state_t          state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [SEL_W-1:0]    sel_q, sel_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic                timeout_q, timeout_d;
  logic [SEL_W-1:0]    nxt;
  logic [NUM_REQ-1:0]  rem;

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    sel_d     = sel_q;
    ptr_d     = ptr_q;
    hold_d    = hold_q;
    timeout_d = 1'b0;
    nxt       = sel_q + 1'b1;
    rem       = req & ~gnt_q;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          state_d = GRANT;
          sel_d   = rr_pick(req, ptr_q);
          gnt_d   = NUM_REQ'(1) << sel_d;
          hold_d  = '0;
        end
      end
      GRANT: begin
        if (out_ready) begin
          // Back-to-back re-grant skips the finishing owner, so no bubble.
          ptr_d = nxt;
          if (|rem) begin
            sel_d  = rr_pick(rem, nxt);
            gnt_d  = NUM_REQ'(1) << sel_d;
            hold_d = '0;
          end else begin
            state_d = IDLE;
            gnt_d   = '0;
          end
        end else if (!req[sel_q]) begin
          state_d = IDLE;
          gnt_d   = '0;
          ptr_d   = nxt;
        end else if (TIMEOUT != 0 && hold_q == HOLD_W'(TIMEOUT - 1)) begin
          state_d   = IDLE;
          gnt_d     = '0;
          ptr_d     = nxt;
          timeout_d = 1'b1;
        end else if (hold_q != {HOLD_W{1'b1}}) begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      sel_q     <= '0;
      ptr_q     <= '0;
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      sel_q     <= sel_d;
      ptr_q     <= ptr_d;
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign gnt       = gnt_q;
  assign sel       = sel_q;
  assign ack       = gnt_q & {NUM_REQ{out_ready}};
  assign out_valid = (state_q == GRANT);
  assign busy      = (state_q == GRANT);
  assign timeout   = timeout_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_mux
    mux_4to1 u_mux (
      .a ({in_data[3*WIDTH+i], in_data[2*WIDTH+i], in_data[WIDTH+i], in_data[i]}),
      .b (sel_q),
      .y (out_data[i])
    );
  end
endmodule

// File: tb/tb_rr_arb_mux_4to1.sv
// Bench for rr_arb_mux_4to1: directed scenarios plus randomized traffic
// against an owner/pointer reference model.
module tb_rr_arb_mux_4to1;
  localparam int W    = 8;
  localparam int T    = 4;
  localparam int HW   = (T == 0) ? 1 : $clog2(T + 1);
  localparam int HMAX = (1 << HW) - 1;

  logic           clk = 1'b0;
  logic           rst;
  logic [3:0]     req;
  logic [4*W-1:0] in_data;
  logic           out_ready;
  logic [3:0]     gnt, ack;
  logic [1:0]     sel;
  logic           out_valid, timeout, busy;
  logic [W-1:0]   out_data;
  logic [W-1:0]   lane [4];

  assign in_data = {lane[3], lane[2], lane[1], lane[0]};

  always #5 clk = ~clk;

  rr_arb_mux_4to1 #(.WIDTH(W), .TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .req(req), .in_data(in_data), .out_ready(out_ready),
    .gnt(gnt), .ack(ack), .sel(sel), .out_valid(out_valid), .out_data(out_data),
    .timeout(timeout), .busy(busy)
  );

  int         n_chk = 0, n_err = 0;
  int         m_own, m_sel, m_ptr, m_hold;
  bit         m_to;
  logic [3:0] ev;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic int pick(logic [3:0] v, int p);
    for (int k = 0; k < 4; k++)
      if (v[(p + k) % 4]) return (p + k) % 4;
    return -1;
  endfunction

  // Apply one cycle of inputs, check outputs against the model, advance model.
  task automatic cyc(input logic r, input logic [3:0] rq, input logic rdy);
    logic [3:0] eg, rem;
    rst = r; req = rq; out_ready = rdy;
    #1;
    eg = (m_own < 0) ? 4'b0 : 4'(1 << m_own);
    chk("gnt", 32'(gnt), 32'(eg));
    chk("sel", 32'(sel), 32'(m_sel));
    chk("out_valid", 32'(out_valid), 32'(m_own >= 0));
    chk("busy", 32'(busy), 32'(m_own >= 0));
    chk("ack", 32'(ack), 32'(eg & {4{rdy}}));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("out_data", 32'(out_data), 32'(lane[m_sel]));
    ev = 4'b0;
    if (r) begin
      m_own = -1; m_sel = 0; m_ptr = 0; m_hold = 0; m_to = 0;
    end else begin
      m_to = 0;
      if (m_own < 0) begin
        if (rq != 0) begin m_own = pick(rq, m_ptr); m_sel = m_own; m_hold = 0; end
      end else if (rdy) begin
        ev = eg; m_ptr = (m_own + 1) % 4; rem = rq & ~eg;
        if (rem != 0) begin m_own = pick(rem, m_ptr); m_sel = m_own; m_hold = 0; end
        else m_own = -1;
      end else if (!rq[m_own]) begin
        m_ptr = (m_own + 1) % 4; m_own = -1;
      end else if (m_hold == T - 1) begin
        ev = eg; m_ptr = (m_own + 1) % 4; m_own = -1; m_to = 1;
      end else if (m_hold < HMAX) begin
        m_hold++;
      end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [3:0] rq;
    logic       r, rdy;
    for (int i = 0; i < 4; i++) lane[i] = '0;
    rst = 1'b1; req = '0; out_ready = 1'b0;
    m_own = -1; m_sel = 0; m_ptr = 0; m_hold = 0; m_to = 0; ev = '0;
    @(posedge clk); #1;

    // single request, immediate transfer
    cyc(1, 4'b0000, 1);
    lane[0] = 8'hA5;
    cyc(0, 4'b0001, 1);
    chk("d1_gnt", 32'(gnt), 32'h1);
    chk("d1_data", 32'(out_data), 32'hA5);
    chk("d1_ack", 32'(ack), 32'h1);
    cyc(0, 4'b0000, 1);

    // full rotation with no bubbles
    cyc(1, 4'b0000, 1);
    lane[0] = 8'h11; lane[1] = 8'h22; lane[2] = 8'h33; lane[3] = 8'h44;
    cyc(0, 4'b1111, 1);
    for (int k = 0; k < 5; k++) begin
      chk("d2_gnt", 32'(gnt), 32'(1 << (k % 4)));
      chk("d2_data", 32'(out_data), 32'(8'h11 * ((k % 4) + 1)));
      cyc(0, 4'b1111, 1);
    end
    cyc(0, 4'b0000, 1);

    // ptr=2 wraps to requester 0 before 1
    cyc(1, 4'b0000, 1);
    cyc(0, 4'b0010, 1);
    cyc(0, 4'b0000, 1);
    cyc(0, 4'b0011, 1);
    chk("d3_gnt0", 32'(gnt), 32'h1);
    cyc(0, 4'b0010, 1);
    chk("d3_gnt1", 32'(gnt), 32'h2);
    cyc(0, 4'b0000, 1);
    chk("d3_idle", 32'(busy), 32'h0);

    // stalled consumer: timeout after T cycles, next grant from ptr=3
    cyc(1, 4'b0000, 0);
    cyc(0, 4'b0100, 0);
    for (int k = 0; k < T; k++) begin
      chk("d4_gnt", 32'(gnt), 32'h4);
      chk("d4_to0", 32'(timeout), 32'h0);
      cyc(0, 4'b0100, 0);
    end
    chk("d4_to1", 32'(timeout), 32'h1);
    chk("d4_rel", 32'(gnt), 32'h0);
    cyc(0, 4'b1111, 0);
    chk("d4_ptr3", 32'(gnt), 32'h8);
    cyc(0, 4'b0000, 1);

    // withdraw, then pending requester 3
    cyc(1, 4'b0000, 0);
    cyc(0, 4'b1001, 0);
    chk("d5_gnt0", 32'(gnt), 32'h1);
    cyc(0, 4'b1000, 0);
    chk("d5_idle", 32'(gnt), 32'h0);
    cyc(0, 4'b1000, 0);
    chk("d5_gnt3", 32'(gnt), 32'h8);
    cyc(0, 4'b0000, 1);

    // reset mid-grant
    cyc(1, 4'b0000, 1);
    cyc(0, 4'b0001, 1);
    chk("d6_gnt", 32'(gnt), 32'h1);
    cyc(1, 4'b0001, 1);
    chk("d6_rgnt", 32'(gnt), 32'h0);
    chk("d6_rvld", 32'(out_valid), 32'h0);
    chk("d6_rack", 32'(ack), 32'h0);
    cyc(0, 4'b0001, 1);
    chk("d6_gnt0", 32'(gnt), 32'h1);
    cyc(0, 4'b0000, 1);

    // randomized traffic honouring the hold-until-ack rule
    rq = 4'b0000;
    for (int n = 0; n < 3000; n++) begin
      r = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 4; i++) begin
        if (!rq[i]) begin
          if ($urandom_range(0, 3) == 0) begin rq[i] = 1'b1; lane[i] = W'($urandom); end
        end else if (ev[i]) begin
          if ($urandom_range(0, 1) == 0) rq[i] = 1'b0;
          else lane[i] = W'($urandom);
        end else if (m_own == i && $urandom_range(0, 15) == 0) begin
          rq[i] = 1'b0;
        end
      end
      rdy = ($urandom_range(0, 9) < 5);
      cyc(r, rq, rdy);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/rr_arb_mux_4to1.md
Name: rr_arb_mux_4to1

Overview:
- Round-robin arbiter and sequencer that shares one 4:1 multiplexed output channel between four requesters.
- Owns the select line of a WIDTH-bit 4:1 mux datapath and issues one-hot grants.
- Runs a valid/ready handshake toward the consumer.
- A hold-timeout counter stops a stalled consumer from locking the channel.

Parameters:
- WIDTH, 8, data width per requester lane.
- TIMEOUT, 16, max cycles a grant may wait on out_ready before forced release; 0 disables the timeout.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- req  input  4  request per requester; must be held until its ack.
- in_data  input  4*WIDTH  lane i = in_data[i*WIDTH +: WIDTH]; must be stable while req[i]=1.
- out_ready  input  1  consumer accepts out_data this cycle.
- gnt  output  4  one-hot registered grant (or 0).
- ack  output  4  combinational: gnt[i] & out_ready; transfer done for requester i.
- sel  output  2  registered mux select; equals index of gnt bit.
- out_valid  output  1  registered; 1 when in GRANT.
- out_data  output  WIDTH  in_data lane selected by sel.
- timeout  output  1  one-cycle pulse when a grant is force-released.
- busy  output  1  1 when state is GRANT.

Behaviour:
- Reset (rst=1 at a clk edge): state=IDLE, gnt=0, sel=0, out_valid=0, busy=0, timeout=0, ptr=0, hold_cnt=0.
  - out_data is then lane 0 (don't-care while out_valid=0).
  - rst mid-grant drops the grant on that edge. No transfer is signalled; ack is 0 in the cycle after reset.
- ptr (2 bits) holds the highest-priority index. Pick = first set bit of the masked request vector, searching ptr, ptr+1, ... mod 4.
- IDLE:
  - If req != 0, go to GRANT next cycle with sel=pick(req, ptr), gnt=1<<sel, hold_cnt=0.
  - Latency is 1 cycle from req to gnt/out_valid.
- GRANT, out_valid=1, evaluated in priority order:
  - Transfer: out_ready=1. ptr <= sel+1 (wraps 3->0).
    - If (req & ~gnt) != 0, re-grant pick(req & ~gnt, sel+1) next cycle with no bubble.
    - Otherwise go to IDLE.
  - Withdraw: req[sel]=0 and out_ready=0. Go to IDLE, ptr <= sel+1, no ack, no timeout pulse.
  - Timeout: TIMEOUT != 0 and hold_cnt == TIMEOUT-1 and out_ready=0. Go to IDLE, ptr <= sel+1, timeout=1 for one cycle.
    - The released requester must re-request.
  - Otherwise: hold_cnt <= hold_cnt+1, saturating; grant unchanged.
- Transfer has priority over timeout in the same cycle.
- A transfer completes even if req[sel] falls in that same cycle.
- Only one requester is ever granted, so gnt is one-hot or zero. sel changes only on the edges listed above.
- hold_cnt width is $clog2(TIMEOUT+1), minimum 1 bit.
- Fairness: after any grant ends, its owner has lowest priority. No requester waits more than 3 grants.

Decomposition:
- Package rr_arb_pkg holds:
  - NUM_REQ=4 and SEL_W=2;
  - typedef enum logic {IDLE, GRANT} arb_state_t;
  - function rr_pick(logic [3:0] v, logic [1:0] ptr) returning logic [1:0].
- One natural sub-module: the existing mux_4to1, instantiated WIDTH times in a generate loop.
  - Instance i gets .a = bit i of each of the four lanes and .b = sel, and drives out_data[i].
- FSM, ptr and hold_cnt stay in the top module.

Test Plan:
- Reset, then req=4'b0001 with lane0=8'hA5 and out_ready=1:
  - gnt=0001, sel=0, out_valid=1, out_data=A5 one cycle after req.
  - ack[0]=1 in that same cycle; ptr becomes 1.
- req=4'b1111 held, out_ready=1 continuously:
  - grants rotate 0,1,2,3,0 on consecutive cycles with no idle cycle between them;
  - out_data follows lanes 11,22,33,44 programmed per lane.
- ptr=2, req=4'b0011 arriving together: grant goes to 0 first, then 1, then IDLE.
- TIMEOUT=4, req=0100, out_ready=0: gnt=0100 for 4 cycles, then a timeout pulse; next grant starts from ptr=3.
- Granted requester drops req with out_ready=0: no ack, IDLE next cycle, pending req[3] granted one cycle later.
- Assert rst for 1 cycle during GRANT with out_ready=1: gnt=0, out_valid=0, ptr=0 next cycle, ack=0.
